// File: rtl/serial_rx_deser_if.sv
// Serial receive bundle: bit-rate serial input, one-deep byte output handshake and link status.
// The master side drives the serial bit and downstream ready; the slave side is the deserializer.
interface serial_rx_deser_if;
  logic       data_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       overflow_err;
  logic       sync_lost;

  modport master (
    output data_in,
    output ready_in,
    input  data_out,
    input  valid_out,
    input  active,
    input  overflow_err,
    input  sync_lost
  );

  modport slave (
    input  data_in,
    input  ready_in,
    output data_out,
    output valid_out,
    output active,
    output overflow_err,
    output sync_lost
  );
endinterface

// File: rtl/serial_rx_deser.sv
// Serial deserializer: bit-granular COM alignment, SYNC_COUNT lock, COM/IDLE strip, byte valid 1 cycle after its last bit.
// One-deep holding register; a byte arriving while full and not ready is dropped (sticky overflow_err). Option: RX_LOSS_DETECT_EN.
module serial_rx_deser #(
  parameter logic [7:0]  COM_CHAR   = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR  = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned LOSS_LIMIT = 64
) (
  input logic              clk,
  input logic              reset,
  serial_rx_deser_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LP_SYNC_CNT = 4'(SYNC_COUNT);

  if (SYNC_COUNT < 2 || SYNC_COUNT > 15) begin : g_bad_sync_count
    $error("serial_rx_deser: SYNC_COUNT must be 2..15");
  end
  if (LOSS_LIMIT < 2 || LOSS_LIMIT > 255) begin : g_bad_loss_limit
    $error("serial_rx_deser: LOSS_LIMIT must be 2..255");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_sr;
  logic [7:0] w_next_sr;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [3:0] r_com_cnt;
  logic [3:0] w_com_cnt_nxt;
  logic       w_boundary;
  logic       w_is_fill;
  logic       w_data_byte;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_overflow_err;

`ifdef RX_LOSS_DETECT_EN
  localparam logic [7:0] LP_LOSS_LIMIT = 8'(LOSS_LIMIT);

  logic [7:0] r_loss_cnt;
  logic [7:0] w_loss_cnt_nxt;
  logic       r_sync_lost;
  logic       w_sync_lost_nxt;
`endif

  // Only seven history bits are kept: the oldest bit falls out on the same edge it would be used.
  assign w_next_sr  = {r_sr, bus.data_in};
  assign w_boundary = (r_state != SEARCH) && (r_bit_cnt == 3'd7);
  assign w_is_fill  = (w_next_sr == COM_CHAR) || (w_next_sr == IDLE_CHAR);

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_com_cnt_nxt   = r_com_cnt;
    w_data_byte     = 1'b0;
`ifdef RX_LOSS_DETECT_EN
    w_loss_cnt_nxt  = r_loss_cnt;
    w_sync_lost_nxt = 1'b0;
`endif
    unique case (r_state)
      SEARCH: begin
        w_bit_cnt_nxt = 3'd0;
        if (w_next_sr == COM_CHAR) begin
          w_state_nxt   = SYNC;
          w_com_cnt_nxt = 4'd1;
        end
      end
      SYNC: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          if (w_next_sr == COM_CHAR) begin
            w_com_cnt_nxt = r_com_cnt + 4'd1;
            if (r_com_cnt + 4'd1 == LP_SYNC_CNT) begin
              w_state_nxt = ACTIVE;
            end
          end else begin
            w_state_nxt   = SEARCH;
            w_bit_cnt_nxt = 3'd0;
            w_com_cnt_nxt = 4'd0;
          end
        end
      end
      ACTIVE: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          w_data_byte = !w_is_fill;
`ifdef RX_LOSS_DETECT_EN
          if (w_is_fill) begin
            w_loss_cnt_nxt = 8'd0;
          end else if (r_loss_cnt + 8'd1 == LP_LOSS_LIMIT) begin
            // The triggering byte is still handed to the holding register above.
            w_state_nxt     = SEARCH;
            w_bit_cnt_nxt   = 3'd0;
            w_com_cnt_nxt   = 4'd0;
            w_loss_cnt_nxt  = 8'd0;
            w_sync_lost_nxt = 1'b1;
          end else begin
            w_loss_cnt_nxt = r_loss_cnt + 8'd1;
          end
`endif
        end
      end
      default: begin
        w_state_nxt   = SEARCH;
        w_bit_cnt_nxt = 3'd0;
        w_com_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_sr      <= 7'd0;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_next_sr[6:0];
      r_bit_cnt <= w_bit_cnt_nxt;
      r_com_cnt <= w_com_cnt_nxt;
    end
  end

  // A consume and a new arrival on the same edge replace the byte without loss.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out     <= 8'd0;
      r_valid_out    <= 1'b0;
      r_overflow_err <= 1'b0;
    end else if (w_data_byte) begin
      if (!r_valid_out || bus.ready_in) begin
        r_data_out  <= w_next_sr;
        r_valid_out <= 1'b1;
      end else begin
        r_overflow_err <= 1'b1;
      end
    end else if (r_valid_out && bus.ready_in) begin
      r_valid_out <= 1'b0;
    end
  end

`ifdef RX_LOSS_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loss_cnt  <= 8'd0;
      r_sync_lost <= 1'b0;
    end else begin
      r_loss_cnt  <= w_loss_cnt_nxt;
      r_sync_lost <= w_sync_lost_nxt;
    end
  end

  assign bus.sync_lost = r_sync_lost;
`else
  assign bus.sync_lost = 1'b0;
`endif

  assign bus.data_out     = r_data_out;
  assign bus.valid_out    = r_valid_out;
  assign bus.active       = (r_state == ACTIVE);
  assign bus.overflow_err = r_overflow_err;

endmodule

// File: tb/tb_serial_rx_deser.sv
// Bench for serial_rx_deser: reset, lock timing, byte filter/handshake table, resync corners, random stream vs queue model.
`timescale 1ns/1ps
module tb_serial_rx_deser;
  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
`ifdef RX_LOSS_DETECT_EN
  localparam int LOSS_LIM = 4;
  localparam int MAX_RUN  = 3;
`else
  localparam int LOSS_LIM = 64;
  localparam int MAX_RUN  = 1000;
`endif

  typedef struct {
    logic [7:0] b;
    logic [7:0] rmask;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_ovf;
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  int         total = 0;
  int         bad   = 0;
  logic       mon_en = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  vec_t       vecs[11];

  serial_rx_deser_if bus();

  serial_rx_deser #(
    .COM_CHAR  (COM),
    .IDLE_CHAR (IDLE),
    .SYNC_COUNT(4),
    .LOSS_LIMIT(LOSS_LIM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One bit period: drive, note a consume that the coming edge will perform, then settle after the edge.
  task automatic step(input logic b, input logic rdy);
    bus.data_in  = b;
    bus.ready_in = rdy;
    if (mon_en && bus.valid_out && rdy) got_q.push_back(bus.data_out);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic [7:0] rmask);
    for (int i = 7; i >= 0; i--) step(v[i], rmask[i]);
  endtask

  task automatic lock(input string tag);
    logic [7:0] c;
    c = COM;
    for (int k = 1; k <= 3; k++) begin
      send_byte(c, 8'hFF);
      check({tag, "_active_before_4th"}, {31'd0, bus.active}, 32'd0);
    end
    for (int i = 7; i >= 1; i--) step(c[i], 1'b1);
    check({tag, "_active_at_bit7"}, {31'd0, bus.active}, 32'd0);
    step(c[0], 1'b1);
    check({tag, "_active_after_bit8"}, {31'd0, bus.active}, 32'd1);
    check({tag, "_valid_idle"}, {31'd0, bus.valid_out}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},     {31'd0, bus.valid_out},    32'd0);
    check({tag, "_data"},      {24'd0, bus.data_out},     32'd0);
    check({tag, "_overflow"},  {31'd0, bus.overflow_err}, 32'd0);
    check({tag, "_active"},    {31'd0, bus.active},       32'd0);
    check({tag, "_sync_lost"}, {31'd0, bus.sync_lost},    32'd0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] rm;
    int         run;
    int         n;

    vecs[0]  = '{8'hA5, 8'hFF, 1'b1, 8'hA5, 1'b0};
    vecs[1]  = '{8'h7C, 8'hFF, 1'b0, 8'hA5, 1'b0};
    vecs[2]  = '{8'h3C, 8'hFF, 1'b1, 8'h3C, 1'b0};
    vecs[3]  = '{8'hBC, 8'h00, 1'b1, 8'h3C, 1'b0};
    vecs[4]  = '{8'h11, 8'h01, 1'b1, 8'h11, 1'b0};
    vecs[5]  = '{8'h22, 8'h01, 1'b1, 8'h22, 1'b0};
    vecs[6]  = '{8'h7C, 8'hFF, 1'b0, 8'h22, 1'b0};
    vecs[7]  = '{8'h11, 8'h00, 1'b1, 8'h11, 1'b0};
    vecs[8]  = '{8'h22, 8'h00, 1'b1, 8'h11, 1'b1};
    vecs[9]  = '{8'h7C, 8'h80, 1'b0, 8'h11, 1'b1};
    vecs[10] = '{8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1};

    bus.data_in  = 1'b0;
    bus.ready_in = 1'b0;
    #12;
    check_all_zero("reset");
    reset = 1'b0;

    // Three junk bits put the COMs at an arbitrary bit offset.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    lock("lock_offset3");

    for (int i = 0; i < 11; i++) begin
      send_byte(vecs[i].b, vecs[i].rmask);
      check($sformatf("vec%0d_valid", i),    {31'd0, bus.valid_out},    {31'd0, vecs[i].exp_vld});
      check($sformatf("vec%0d_data", i),     {24'd0, bus.data_out},     {24'd0, vecs[i].exp_dat});
      check($sformatf("vec%0d_overflow", i), {31'd0, bus.overflow_err}, {31'd0, vecs[i].exp_ovf});
      check($sformatf("vec%0d_active", i),   {31'd0, bus.active},       32'd1);
    end

    // Reset mid-byte with a byte still pending.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("pre_reset_valid", {31'd0, bus.valid_out}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two COMs then a non-COM boundary falls back to SEARCH; four fresh COMs are needed.
    send_byte(COM, 8'hFF);
    send_byte(COM, 8'hFF);
    check("sync2_active", {31'd0, bus.active}, 32'd0);
    send_byte(8'h55, 8'hFF);
    check("sync_fail_active", {31'd0, bus.active}, 32'd0);
    lock("relock");

`ifdef RX_LOSS_DETECT_EN
    for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 8'hFF);
    send_byte(COM, 8'hFF);
    check("loss3_active", {31'd0, bus.active}, 32'd1);
    check("loss3_sync_lost", {31'd0, bus.sync_lost}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 8'hFF);
    check("loss4_sync_lost", {31'd0, bus.sync_lost}, 32'd1);
    check("loss4_active", {31'd0, bus.active}, 32'd0);
    check("loss4_valid", {31'd0, bus.valid_out}, 32'd1);
    check("loss4_data", {24'd0, bus.data_out}, 32'h53);
    step(1'b0, 1'b1);
    check("loss_pulse_end", {31'd0, bus.sync_lost}, 32'd0);
`else
    for (int i = 0; i < 6; i++) send_byte(8'h50 + 8'(i), 8'hFF);
    check("persist_active", {31'd0, bus.active}, 32'd1);
    check("persist_sync_lost", {31'd0, bus.sync_lost}, 32'd0);
    check("persist_data", {24'd0, bus.data_out}, 32'h55);
`endif

    // Random stream: ready is random except on boundary bits, so no byte may be lost.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    n = $urandom_range(0, 7);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    lock("rand_lock");
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    run = 0;
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(0, 9);
      if (run >= MAX_RUN || n < 2) begin
        v = COM;
      end else if (n < 4) begin
        v = IDLE;
      end else begin
        v = 8'($urandom);
        if (v == COM || v == IDLE) v = 8'h00;
      end
      if (v == COM || v == IDLE) begin
        run = 0;
      end else begin
        run++;
        exp_q.push_back(v);
      end
      rm = 8'($urandom) | 8'h01;
      send_byte(v, rm);
    end
    send_byte(IDLE, 8'hFF);
    mon_en = 1'b0;
    check("rand_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("rand_byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    check("rand_overflow", {31'd0, bus.overflow_err}, 32'd0);
    check("rand_active", {31'd0, bus.active}, 32'd1);
    check("rand_valid_drained", {31'd0, bus.valid_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
